// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ctrl_pkg
//  Desc    : Shared types and constants for the core control sequencer:
//            FSM state encoding, src1 operand selects, instruction classes.
//  Rev     : 1.0  initial release
// ============================================================================
package ctrl_pkg;

    // Sequencer states; explicit 3-bit encoding
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EX_DP   = 3'd2,
        EX_ADDR = 3'd3,
        MEM_ACC = 3'd4,
        EX_BR   = 3'd5,
        EX_MUL  = 3'd6,
        WB      = 3'd7
    } state_t;

    // ALU src1 multiplexer selects
    localparam logic [1:0] SRC1_RN   = 2'b00;
    localparam logic [1:0] SRC1_RS   = 2'b01;
    localparam logic [1:0] SRC1_PC   = 2'b10;
    localparam logic [1:0] SRC1_ZERO = 2'b11;

    // Instruction class codes held in ir[27:26]
    localparam logic [1:0] CLS_DP  = 2'b00;
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_MUL = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mul_cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module  : mul_cycle_counter
//  Desc    : Counts busy cycles of an iterative multiply. Counts while
//            enabled, flags done on the last cycle and wraps to zero there.
//  Rev     : 1.0  initial release
// ============================================================================
module mul_cycle_counter #(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic done
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MUL_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_done;

    assign w_done = (r_cnt == C_LAST);
    assign done   = w_done;

    // Cycle counter: clear has priority, wrap on the last multiply cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/src1_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : src1_ctrl_fsm
//  Desc    : Multi-cycle control sequencer. Fetches an instruction over a
//            ready/valid handshake, decodes its class and drives the per-
//            cycle control word, including the ALU src1 operand select.
//  Rev     : 1.0  initial release
// ============================================================================
module src1_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  src1_sel,
    output logic        alu_en,
    output logic        pc_en,
    output logic        pc_load,
    output logic        reg_we,
    output logic        busy
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_ir;
    logic [1:0]  w_cls;
    logic        w_is_load;
    logic        w_mul_done;

    assign ir        = r_ir;
    assign w_cls     = r_ir[27:26];
    assign w_is_load = r_ir[20];

    mul_cycle_counter #(
        .MUL_CYCLES (MUL_CYCLES),
        .CNT_W      (CNT_W)
    ) u_mul_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_state == EX_MUL),
        .clr   (r_state == DECODE),
        .done  (w_mul_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Instruction register: captured only on a completed fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ir <= '0;
        end else if ((r_state == FETCH) && mem_ready) begin
            r_ir <= mem_rdata;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH:   if (mem_ready) w_state_nxt = DECODE;
            DECODE: begin
                case (w_cls)
                    CLS_DP:  w_state_nxt = EX_DP;
                    CLS_MEM: w_state_nxt = EX_ADDR;
                    CLS_BR:  w_state_nxt = EX_BR;
                    default: w_state_nxt = EX_MUL;
                endcase
            end
            EX_DP:   w_state_nxt = WB;
            EX_ADDR: w_state_nxt = MEM_ACC;
            MEM_ACC: if (mem_ready) w_state_nxt = w_is_load ? WB : FETCH;
            EX_BR:   w_state_nxt = FETCH;
            EX_MUL:  if (w_mul_done) w_state_nxt = WB;
            WB:      w_state_nxt = FETCH;
            default: w_state_nxt = FETCH;
        endcase
    end

    // Control word decode; everything held idle while reset is asserted
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        src1_sel = SRC1_ZERO;
        alu_en   = 1'b0;
        pc_en    = 1'b0;
        pc_load  = 1'b0;
        reg_we   = 1'b0;
        busy     = 1'b0;
        if (rst_n) begin
            busy = (r_state != FETCH);
            case (r_state)
                FETCH: begin
                    mem_req = 1'b1;
                    pc_en   = mem_ready;
                end
                EX_DP, EX_ADDR: begin
                    src1_sel = SRC1_RN;
                    alu_en   = 1'b1;
                end
                MEM_ACC: begin
                    mem_req  = 1'b1;
                    mem_we   = ~w_is_load;
                    src1_sel = SRC1_RN;
                end
                EX_BR: begin
                    src1_sel = SRC1_PC;
                    alu_en   = 1'b1;
                    pc_en    = 1'b1;
                    pc_load  = 1'b1;
                end
                EX_MUL: begin
                    src1_sel = SRC1_RS;
                    alu_en   = 1'b1;
                end
                WB:      reg_we = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_src1_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : tb_src1_ctrl_fsm
//  Desc    : Self-checking bench for src1_ctrl_fsm. Each instruction is
//            expanded into its expected per-cycle control words from the
//            class rules and compared cycle by cycle.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_src1_ctrl_fsm;

    localparam int MUL_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic        mem_req, mem_we, alu_en, pc_en, pc_load, reg_we, busy;
    logic [1:0]  src1_sel;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ir   = '0;

    // expected per-cycle control words and the mem_ready policy per cycle
    // (0 drive low, 1 drive high, 2 random: DUT must ignore it)
    logic [8:0]  q_vec[$];
    int          q_rdy[$];

    src1_ctrl_fsm #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .src1_sel  (src1_sel),
        .alu_en    (alu_en),
        .pc_en     (pc_en),
        .pc_load   (pc_load),
        .reg_we    (reg_we),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    wire [8:0] obs_vec = {mem_req, mem_we, src1_sel, alu_en, pc_en, pc_load, reg_we, busy};
    localparam logic [8:0] RESET_VEC = 9'b0_0_11_0_0_0_0_0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] mk(input logic req, input logic we, input logic [1:0] s1,
                                      input logic alu, input logic pce, input logic pcl,
                                      input logic rwe, input logic bsy);
        return {req, we, s1, alu, pce, pcl, rwe, bsy};
    endfunction

    task automatic push(input logic [8:0] v, input int r);
        q_vec.push_back(v);
        q_rdy.push_back(r);
    endtask

    // Expand one instruction into its expected cycle sequence and check it.
    // fw/mw: wait cycles before fetch / memory-access ready.
    // abort_at: cycle index at which reset is asserted instead (-1 = none).
    task automatic run_instr(input logic [31:0] instr, input int fw, input int mw, input int abort_at);
        logic is_load;
        is_load = instr[20];
        q_vec.delete();
        q_rdy.delete();
        for (int i = 0; i < fw; i++) push(mk(1, 0, 2'b11, 0, 0, 0, 0, 0), 0);
        push(mk(1, 0, 2'b11, 0, 1, 0, 0, 0), 1);
        push(mk(0, 0, 2'b11, 0, 0, 0, 0, 1), 2);
        case (instr[27:26])
            2'b00: begin
                push(mk(0, 0, 2'b00, 1, 0, 0, 0, 1), 2);
                push(mk(0, 0, 2'b11, 0, 0, 0, 1, 1), 2);
            end
            2'b01: begin
                push(mk(0, 0, 2'b00, 1, 0, 0, 0, 1), 2);
                for (int i = 0; i < mw; i++) push(mk(1, ~is_load, 2'b00, 0, 0, 0, 0, 1), 0);
                push(mk(1, ~is_load, 2'b00, 0, 0, 0, 0, 1), 1);
                if (is_load) push(mk(0, 0, 2'b11, 0, 0, 0, 1, 1), 2);
            end
            2'b10: begin
                push(mk(0, 0, 2'b10, 1, 1, 1, 0, 1), 2);
            end
            default: begin
                for (int i = 0; i < MUL_CYCLES; i++) push(mk(0, 0, 2'b01, 1, 0, 0, 0, 1), 2);
                push(mk(0, 0, 2'b11, 0, 0, 0, 1, 1), 2);
            end
        endcase
        for (int i = 0; i < q_vec.size(); i++) begin
            if (i == abort_at) begin
                rst_n     = 1'b0;
                mem_ready = 1'b1;
                return;
            end
            mem_ready = (q_rdy[i] == 2) ? 1'($urandom_range(0, 1)) : (q_rdy[i] == 1);
            mem_rdata = (i == fw) ? instr : $urandom;
            #1;
            chk("ctrl_word", {23'd0, obs_vec}, {23'd0, q_vec[i]});
            chk("ir", ir, exp_ir);
            chk("inv_pcload", {31'd0, pc_load & ~pc_en}, 32'd0);
            chk("inv_wb_req", {31'd0, reg_we & mem_req}, 32'd0);
            if (i == fw) exp_ir = instr;
            @(negedge clk);
        end
    endtask

    // Reset was just asserted at a negedge: outputs idle now and after the edge
    task automatic finish_abort();
        #1;
        chk("abort_now", {23'd0, obs_vec}, {23'd0, RESET_VEC});
        @(posedge clk);
        #1;
        chk("abort_edge", {23'd0, obs_vec}, {23'd0, RESET_VEC});
        chk("abort_ir", ir, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_ir = '0;
    endtask

    logic [31:0] rnd;

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_ctrl", {23'd0, obs_vec}, {23'd0, RESET_VEC});
            chk("reset_ir", ir, 32'd0);
        end
        rst_n = 1'b1;

        // directed: DP, load with 2 waits, store, branch, multiply
        run_instr(32'h0000_0000, 0, 0, -1);
        run_instr(32'h0410_0000, 0, 2, -1);
        run_instr(32'h0400_0000, 0, 0, -1);
        run_instr(32'h0800_0000, 1, 0, -1);
        run_instr(32'h0C00_0000, 0, 0, -1);

        // randomized instructions and wait states
        for (int n = 0; n < 60; n++) begin
            rnd = $urandom;
            run_instr(rnd, $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        // reset during the second EX_MUL cycle
        run_instr(32'h0C00_0000, 0, 0, 3);
        finish_abort();
        run_instr(32'h0C00_1234, 0, 0, -1);

        // reset during a MEM_ACC wait of a load
        run_instr(32'h0410_0000, 0, 3, 4);
        finish_abort();
        run_instr(32'h0410_5678, 1, 1, -1);
        run_instr(32'h0000_0042, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/src1_ctrl_fsm.md
Name: src1_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the processor core.
- Fetches each instruction over a ready/valid memory handshake, latches it, decodes its class and drives the per-cycle control word.
- The control word includes the 2-bit src1 operand select (Rn / Rs / PC / zero) for the ALU src1 multiplexer.
- Owns multi-cycle sequencing: memory waits and an iterative multiply busy period.

Parameters:
- MUL_CYCLES, 4, number of EXEC cycles a multiply occupies (must be >=1)
- CNT_W, 3, width of multiply cycle counter (must satisfy 2^CNT_W > MUL_CYCLES)

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- mem_ready  in  1  memory completed current request this cycle
- mem_rdata  in  32  instruction word returned by memory
- ir  out  32  latched instruction register
- mem_req  out  1  memory request valid
- mem_we  out  1  write strobe (valid with mem_req)
- src1_sel  out  2  src1 mux select: 00 Rn, 01 Rs, 10 PC, 11 zero
- alu_en  out  1  ALU result register enable
- pc_en  out  1  PC update enable
- pc_load  out  1  PC loads branch target (else PC+4 when pc_en)
- reg_we  out  1  register-file write enable
- busy  out  1  high whenever state != FETCH

Behaviour:
- Synchronous, active-low reset.
  - While rst_n=0: state=FETCH, ir=0, mul_cnt=0.
  - All outputs forced: mem_req=0, mem_we=0, src1_sel=11, alu_en=0, pc_en=0, pc_load=0, reg_we=0, busy=0.
  - First request is issued the cycle after rst_n rises.
  - Reset asserted mid-transaction aborts it: any pending mem_req drops on the next edge, and no writeback occurs.
- Outputs are Moore (registered state, combinational decode of state + ir). Exception: ir is registered.
- Instruction class comes from ir[27:26]: 00 DP, 01 MEM, 10 BR, 11 MUL.
  - ir[20]=1 means load, 0 means store.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, src1_sel=11.
    - mem_ready=1: ir<=mem_rdata, pc_en=1 (PC+4), go DECODE.
    - Otherwise stay in FETCH; mem_req is held high until ready.
  - DECODE (1 cycle): src1_sel=11. Next state by class: DP->EX_DP, MEM->EX_ADDR, BR->EX_BR, MUL->EX_MUL (mul_cnt<=0).
  - EX_DP: src1_sel=00, alu_en=1 -> WB.
  - EX_ADDR: src1_sel=00, alu_en=1 -> MEM_ACC.
  - MEM_ACC: mem_req=1, mem_we=~ir[20], src1_sel=00. Waits for mem_ready.
    - On ready: load -> WB; store -> FETCH.
  - EX_BR: src1_sel=10, alu_en=1, pc_en=1, pc_load=1 -> FETCH. No writeback.
  - EX_MUL: src1_sel=01, alu_en=1, mul_cnt increments each cycle.
    - When mul_cnt==MUL_CYCLES-1: mul_cnt<=0, go WB.
    - Total EX_MUL residency is exactly MUL_CYCLES cycles.
  - WB: reg_we=1 for exactly one cycle, src1_sel=11 -> FETCH.
- Latency from FETCH ready edge to the next FETCH (zero memory wait):
  - DP: 3 cycles
  - BR: 2 cycles
  - store: 3 cycles
  - load: 4 cycles
  - MUL: 2+MUL_CYCLES cycles
- Invariants:
  - pc_load implies pc_en.
  - reg_we and mem_req are never high together.
  - src1_sel=11 in every state that does not use src1.
- mem_ready while mem_req=0 is ignored.
- mem_rdata is sampled only in FETCH with mem_ready=1.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (FETCH, DECODE, EX_DP, EX_ADDR, MEM_ACC, EX_BR, EX_MUL, WB)
  - src1_sel localparams SRC1_RN=2'b00, SRC1_RS=2'b01, SRC1_PC=2'b10, SRC1_ZERO=2'b11
  - class codes CLS_DP/MEM/BR/MUL
- One sub-module is natural: mul_cycle_counter (enable, clear, done at MUL_CYCLES-1), reused by the future multiplier.
- FSM next-state and output decode stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 -> all outputs zero except src1_sel=11. Release -> mem_req=1 on the first cycle.
- DP: fetch ir=32'h0000_0000 with mem_ready=1 -> DECODE, then EX_DP with src1_sel=00, alu_en=1, then WB with reg_we=1, then FETCH 3 cycles after the fetch edge.
- Load with 2 wait cycles: ir=32'h0410_0000 (class 01, L=1); mem_ready low for 2 cycles in MEM_ACC -> mem_req held, mem_we=0, src1_sel=00. Ready -> WB reg_we=1.
- Store: ir=32'h0400_0000 -> MEM_ACC has mem_we=1, then FETCH directly; reg_we is never asserted.
- Branch/multiply:
  - ir=32'h0800_0000 -> EX_BR with src1_sel=10, pc_en=pc_load=1.
  - ir=32'h0C00_0000 with MUL_CYCLES=4 -> src1_sel=01 for exactly 4 cycles, then WB.
- Reset mid-MUL and mid-MEM_ACC (rst_n=0 at cycle 2 of EX_MUL, and during a MEM_ACC wait) -> next edge returns to reset outputs, no reg_we, mem_req dropped, mul_cnt=0.
